// File: rtl/rect_grid_memory_pkg.sv
// Shared definitions for the snake game grid memory and its controller.
//   - Function codes stored per grid cell.
//   - Grid geometry (cells per row/column, cell size in pixels).
//   - Packed layouts of the 36-bit rect write word and 32-bit read address.
//   - FSM state encoding and the cell range check helper.
package rect_grid_memory_pkg;

   // Cell function codes
   localparam logic [3:0] FUNC_NULL  = 4'b0000;
   localparam logic [3:0] FUNC_SNAKE = 4'b0001;
   localparam logic [3:0] FUNC_ROCK  = 4'b0010;
   localparam logic [3:0] FUNC_SNACK = 4'b0100;

   // Grid geometry; GRID_SIZE_X must stay a power of two (x is the low address bits)
   localparam int GRID_SIZE_X = 32;
   localparam int GRID_SIZE_Y = 24;
   localparam int CELL_LOG2   = 5;

   localparam int IDX_W  = 5;            // bits per x / y cell index
   localparam int ADDR_W = 2 * IDX_W;    // {y[4:0], x[4:0]}

   localparam logic [15:0]       X_LIM     = 16'(GRID_SIZE_X);
   localparam logic [15:0]       Y_LIM     = 16'(GRID_SIZE_Y);
   localparam logic [10:0]       H_PIX_LIM = 11'(GRID_SIZE_X << CELL_LOG2);
   localparam logic [10:0]       V_PIX_LIM = 11'(GRID_SIZE_Y << CELL_LOG2);
   localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(GRID_SIZE_X * GRID_SIZE_Y - 1);

   // {x[15:0], y[15:0], func[3:0]}
   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic [3:0]  func;
   } rect_write_t;

   // {x[15:0], y[15:0]}
   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
   } rect_addr_t;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } grid_state_e;

   // True when the full 16-bit coordinate lies inside the play grid
   function automatic logic in_grid(input logic [15:0] x, input logic [15:0] y);
      return (x < X_LIM) && (y < Y_LIM);
   endfunction

endpackage

// File: rtl/rect_grid_memory_grid_ram_1w2r.sv
// Grid storage: 1024 x 4 bits, one synchronous write port and two
// asynchronous read ports. No reset; the owner sweeps it clear.
//   clk            system clock
//   we/waddr/wdata write port, applied at the rising edge
//   raddr0/rdata0  read port 0 (controller lookup), combinational
//   raddr1/rdata1  read port 1 (pixel lookup), combinational
module rect_grid_memory_grid_ram_1w2r
   import rect_grid_memory_pkg::*;
(
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [3:0]        wdata,
   input  logic [ADDR_W-1:0] raddr0,
   output logic [3:0]        rdata0,
   input  logic [ADDR_W-1:0] raddr1,
   output logic [3:0]        rdata1
);

   logic [3:0] mem [0:(1<<ADDR_W)-1];

   // Write port
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read ports see the pre-write contents within the cycle of a write
   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];

endmodule

// File: rtl/rect_grid_memory.sv
// Responder for the snake controller's rect interface: holds one function
// code per cell of the 32x24 grid and clears itself after reset or on request.
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           1-cycle pulse, (re)starts the clear sweep
//   rect_write      {x, y, func}; stored when in range and idle
//   rect_read_addr  {x, y}; rect_read_data one cycle later (ROCK off-grid)
//   hcount, vcount  renderer pixel; pix_func one cycle later (NULL off-screen)
//   busy            high while the clear sweep runs
module rect_grid_memory
   import rect_grid_memory_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic [35:0] rect_write,
   input  logic [31:0] rect_read_addr,
   output logic [3:0]  rect_read_data,
   input  logic [10:0] hcount,
   input  logic [10:0] vcount,
   output logic [3:0]  pix_func,
   output logic        busy
);

   grid_state_e       state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic              busy_q, busy_d;
   logic [3:0]        rd_data_q, rd_data_d;
   logic [3:0]        pix_q, pix_d;

   rect_write_t       wr_s;
   rect_addr_t        rd_s;
   logic              wr_in_range_s;
   logic              rd_in_range_s;
   logic              pix_in_range_s;

   logic              ram_we_s;
   logic [ADDR_W-1:0] ram_waddr_s;
   logic [3:0]        ram_wdata_s;
   logic [ADDR_W-1:0] ram_raddr0_s;
   logic [ADDR_W-1:0] ram_raddr1_s;
   logic [3:0]        ram_rdata0_s;
   logic [3:0]        ram_rdata1_s;

   assign wr_s = rect_write_t'(rect_write);
   assign rd_s = rect_addr_t'(rect_read_addr);

   // Range checks on full-width coordinates so aliased indices never hit the grid
   always_comb begin
      wr_in_range_s  = in_grid(wr_s.x, wr_s.y);
      rd_in_range_s  = in_grid(rd_s.x, rd_s.y);
      pix_in_range_s = (hcount < H_PIX_LIM) && (vcount < V_PIX_LIM);
      ram_raddr0_s   = {rd_s.y[IDX_W-1:0], rd_s.x[IDX_W-1:0]};
      ram_raddr1_s   = {vcount[CELL_LOG2 +: IDX_W], hcount[CELL_LOG2 +: IDX_W]};
   end

   rect_grid_memory_grid_ram_1w2r u_grid_ram_1w2r (
      .clk    (clk),
      .we     (ram_we_s),
      .waddr  (ram_waddr_s),
      .wdata  (ram_wdata_s),
      .raddr0 (ram_raddr0_s),
      .rdata0 (ram_rdata0_s),
      .raddr1 (ram_raddr1_s),
      .rdata1 (ram_rdata1_s)
   );

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_CLEAR;
         cnt_q     <= {ADDR_W{1'b0}};
         busy_q    <= 1'b1;
         rd_data_q <= FUNC_NULL;
         pix_q     <= FUNC_NULL;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         rd_data_q <= rd_data_d;
         pix_q     <= pix_d;
      end
   end

   // Next state and sweep counter; a clear pulse always restarts from cell 0
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = ST_CLEAR;
         cnt_d   = {ADDR_W{1'b0}};
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (cnt_q == CNT_LAST) begin
                  state_d = ST_IDLE;
                  cnt_d   = {ADDR_W{1'b0}};
               end else begin
                  state_d = ST_CLEAR;
                  cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end
            ST_IDLE: begin
               state_d = ST_IDLE;
               cnt_d   = {ADDR_W{1'b0}};
            end
            default: begin
               state_d = ST_CLEAR;
               cnt_d   = {ADDR_W{1'b0}};
            end
         endcase
      end
   end

   // RAM write steering and registered read results
   always_comb begin
      ram_we_s    = 1'b0;
      ram_waddr_s = {ADDR_W{1'b0}};
      ram_wdata_s = FUNC_NULL;
      rd_data_d   = FUNC_NULL;
      pix_d       = FUNC_NULL;
      // busy tracks the state being entered so it drops with the last sweep write
      busy_d      = (state_d == ST_CLEAR);
      case (state_q)
         ST_CLEAR: begin
            ram_we_s    = 1'b1;
            ram_waddr_s = cnt_q;
            ram_wdata_s = FUNC_NULL;
            rd_data_d   = FUNC_NULL;
            pix_d       = FUNC_NULL;
         end
         ST_IDLE: begin
            ram_we_s    = wr_in_range_s;
            ram_waddr_s = {wr_s.y[IDX_W-1:0], wr_s.x[IDX_W-1:0]};
            ram_wdata_s = wr_s.func;
            // Off-grid lookups read as walls
            if (rd_in_range_s) begin
               rd_data_d = ram_rdata0_s;
            end else begin
               rd_data_d = FUNC_ROCK;
            end
            if (pix_in_range_s) begin
               pix_d = ram_rdata1_s;
            end else begin
               pix_d = FUNC_NULL;
            end
         end
         default: begin
            ram_we_s  = 1'b0;
            rd_data_d = FUNC_NULL;
            pix_d     = FUNC_NULL;
         end
      endcase
   end

   assign rect_read_data = rd_data_q;
   assign pix_func       = pix_q;
   assign busy           = busy_q;

endmodule
